// File: rtl/r4k_pkg.sv
// Shared types and constants for the R4K memory arbiter.
package r4k_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  localparam logic [7:0]  MASK_ALL    = 8'hFF;
  localparam logic [63:0] DWORD_ALIGN = {{61{1'b1}}, 3'b000};

  function automatic logic [63:0] dword_addr(input logic [63:0] addr);
    return addr & DWORD_ALIGN;
  endfunction

endpackage

// File: rtl/r4k_mem_arbiter.sv
// Arbitrates R4K fetch and data ports onto one 64-bit req/gnt/rvalid memory port,
// one transaction at a time, returning each completion as a one-cycle ready pulse.
module r4k_mem_arbiter
  import r4k_pkg::*;
#(
  parameter int unsigned MAX_DATA_RUN = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] instr_address,
  input  logic        instr_read,
  output logic [31:0] instr_in,
  output logic        instr_ready,
  input  logic [63:0] data_address,
  input  logic [63:0] data_out,
  input  logic [7:0]  data_mask,
  input  logic        data_read,
  input  logic        data_write,
  output logic [63:0] data_in,
  output logic        data_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_mask,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic        protocol_err
);

  localparam logic [3:0] RUN_LIMIT = 4'(MAX_DATA_RUN);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  owner_t     r_owner;
  logic       r_is_write;
  logic       r_sel_hi;
  logic [3:0] r_run_cnt;

  logic w_data_req;
  logic w_run_full;
  logic w_grant_data;
  logic w_grant_instr;

  always_comb begin
    w_data_req    = data_read | data_write;
    w_run_full    = (r_run_cnt == RUN_LIMIT);
    w_grant_data  = 1'b0;
    w_grant_instr = 1'b0;
    w_state_nxt   = r_state;
    unique case (r_state)
      IDLE: begin
        // Data wins unless it has used up its run while a fetch is waiting.
        if (w_data_req && !(instr_read && w_run_full)) begin
          w_grant_data = 1'b1;
          w_state_nxt  = ISSUE;
        end else if (instr_read) begin
          w_grant_instr = 1'b1;
          w_state_nxt   = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_gnt) begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_run_cnt <= '0;
    end else if (r_state == IDLE) begin
      if (w_grant_instr || !instr_read) begin
        r_run_cnt <= '0;
      end else if (w_grant_data) begin
        r_run_cnt <= r_run_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner    <= OWN_INSTR;
      r_is_write <= 1'b0;
      r_sel_hi   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_mask   <= '0;
    end else begin
      if (w_grant_data) begin
        r_owner    <= OWN_DATA;
        r_is_write <= data_write;
        r_sel_hi   <= 1'b0;
        mem_req    <= 1'b1;
        mem_we     <= data_write;
        mem_addr   <= dword_addr(data_address);
        mem_wdata  <= data_write ? data_out : '0;
        mem_mask   <= data_write ? data_mask : MASK_ALL;
      end else if (w_grant_instr) begin
        r_owner    <= OWN_INSTR;
        r_is_write <= 1'b0;
        r_sel_hi   <= instr_address[2];
        mem_req    <= 1'b1;
        mem_we     <= 1'b0;
        mem_addr   <= dword_addr(instr_address);
        mem_wdata  <= '0;
        mem_mask   <= MASK_ALL;
      end else if (r_state == ISSUE && mem_gnt) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_in    <= '0;
      instr_ready <= 1'b0;
      data_in     <= '0;
      data_ready  <= 1'b0;
    end else begin
      instr_ready <= 1'b0;
      data_ready  <= 1'b0;
      if (r_state == WAIT && mem_rvalid) begin
        if (r_owner == OWN_INSTR) begin
          instr_in    <= r_sel_hi ? mem_rdata[63:32] : mem_rdata[31:0];
          instr_ready <= 1'b1;
        end else begin
          // Store acknowledges carry no data; leave the last load result intact.
          if (!r_is_write) begin
            data_in <= mem_rdata;
          end
          data_ready <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      protocol_err <= 1'b0;
    end else if ((r_state == IDLE && data_read && data_write) ||
                 (r_state != WAIT && mem_rvalid)) begin
      protocol_err <= 1'b1;
    end
  end

endmodule
